// File: rtl/slave_mem_if.sv
// Request/response channel bundle between a bus master and slave_mem.
// The A channel carries requests toward the slave; the D channel carries responses back.
interface slave_mem_if #(
    parameter int a_channel_size = 53,
    parameter int d_channel_size = 43
);
    logic [a_channel_size-1:0] a_channel;
    logic                      a_valid;
    logic                      a_ready;
    logic [d_channel_size-1:0] d_channel;
    logic                      d_valid;
    logic                      d_error;
    logic                      d_ready;
    logic                      backpressureslave;

    modport master (
        output a_channel, a_valid, d_ready,
        input  a_ready, d_channel, d_valid, d_error, backpressureslave
    );

    modport slave (
        input  a_channel, a_valid, d_ready,
        output a_ready, d_channel, d_valid, d_error, backpressureslave
    );
endinterface

// File: rtl/slave_mem.sv
// Single-outstanding memory slave: accepts one Get/PutFullData request at a time,
// performs it against a word-addressed memory and returns a registered response.
module slave_mem #(
    parameter int a_channel_size = 53,
    parameter int d_channel_size = 43,
    parameter int MEM_DEPTH      = 256
) (
    input  logic       clk,
    input  logic       reset,
    slave_mem_if.slave bus
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [2:0] OP_PUT      = 3'd0;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    logic [1:0]                state_q, state_d;
    logic                      a_ready_q, a_ready_d;
    logic                      d_valid_q, d_valid_d;
    logic                      d_error_q, d_error_d;
    logic [d_channel_size-1:0] d_channel_q, d_channel_d;
    logic [a_channel_size-1:0] req_q, req_d;
    logic [31:0]               mem_q [MEM_DEPTH];

    logic [2:0]  req_opcode, req_param, req_size;
    logic [1:0]  req_source;
    logic [9:0]  req_addr;
    logic [31:0] req_data;
    logic [AW-1:0] req_idx;
    logic        req_legal;
    logic        mem_we;
    logic [2:0]  rsp_opcode;
    logic [31:0] rsp_data;

    // Full 10-bit address is compared so out-of-range addresses never alias into memory.
    function automatic logic is_legal(input logic [2:0] op, input logic [2:0] prm,
                                      input logic [2:0] sz, input logic [9:0] addr);
        return ((op == OP_GET) || (op == OP_PUT)) && (prm == 3'd0) && (sz == 3'd5)
               && (int'({22'd0, addr}) < MEM_DEPTH);
    endfunction

    assign req_opcode = req_q[52:50];
    assign req_param  = req_q[49:47];
    assign req_size   = req_q[46:44];
    assign req_source = req_q[43:42];
    assign req_addr   = req_q[41:32];
    assign req_data   = req_q[31:0];
    assign req_idx    = req_addr[AW-1:0];
    assign req_legal  = is_legal(req_opcode, req_param, req_size, req_addr);
    assign rsp_opcode = (req_opcode == OP_GET) ? OP_ACK_DATA : OP_ACK;
    assign rsp_data   = (req_legal && (req_opcode == OP_GET)) ? mem_q[req_idx] : 32'd0;

    always_comb begin
        state_d     = state_q;
        a_ready_d   = a_ready_q;
        d_valid_d   = d_valid_q;
        d_error_d   = d_error_q;
        d_channel_d = d_channel_q;
        req_d       = req_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_ready_q && bus.a_valid) begin
                    req_d     = bus.a_channel;
                    a_ready_d = 1'b0;
                    state_d   = ACCESS;
                end else begin
                    a_ready_d = 1'b1;
                end
            end
            ACCESS: begin
                d_valid_d   = 1'b1;
                d_error_d   = ~req_legal;
                d_channel_d = {rsp_opcode, 3'd0, req_size, req_source, rsp_data};
                mem_we      = req_legal && (req_opcode == OP_PUT);
                state_d     = RESP;
            end
            RESP: begin
                if (bus.d_ready) begin
                    d_valid_d = 1'b0;
                    d_error_d = 1'b0;
                    a_ready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                a_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_ready_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            d_error_q   <= 1'b0;
            d_channel_q <= '0;
        end else begin
            state_q     <= state_d;
            a_ready_q   <= a_ready_d;
            d_valid_q   <= d_valid_d;
            d_error_q   <= d_error_d;
            d_channel_q <= d_channel_d;
        end
    end

    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    // Memory is never cleared; reset only blocks a write that would land on the reset edge.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[req_idx] <= req_data;
        end
    end

    assign bus.a_ready           = a_ready_q;
    assign bus.backpressureslave = ~a_ready_q;
    assign bus.d_valid           = d_valid_q;
    assign bus.d_error           = d_error_q;
    assign bus.d_channel         = d_channel_q;
endmodule

// File: tb/tb_slave_mem.sv
// Bench for slave_mem: table of requests with expected responses fed through a scoreboard,
// plus hand-written sequences for reset, backpressure, reset-during-access and retry.
module tb_slave_mem;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    slave_mem_if #(.a_channel_size(53), .d_channel_size(43)) bus ();

    slave_mem #(.a_channel_size(53), .d_channel_size(43), .MEM_DEPTH(256)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  prm;
        logic [2:0]  sz;
        logic [1:0]  src;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [2:0]  e_op;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic [2:0]  sz;
        logic [1:0]  src;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                                input logic [1:0] src, input logic [9:0] addr, input logic [31:0] data,
                                input logic [2:0] e_op, input logic e_err, input logic [31:0] e_data);
        vec_t v;
        v.op = op; v.prm = prm; v.sz = sz; v.src = src; v.addr = addr; v.data = data;
        v.e_op = e_op; v.e_err = e_err; v.e_data = e_data;
        return v;
    endfunction

    task automatic send(input vec_t v, input int hold);
        int   n;
        exp_t e;
        logic [42:0] ew;
        n = 0;
        while (bus.a_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_wait", 64'(n < 20), 64'd1);
        bus.a_channel = {v.op, v.prm, v.sz, v.src, v.addr, v.data};
        bus.a_valid   = 1'b1;
        sb.push_back('{op: v.e_op, err: v.e_err, sz: v.sz, src: v.src, data: v.e_data});
        @(negedge clk);
        bus.a_valid   = 1'b0;
        bus.a_channel = '0;
        chk("access_d_valid", 64'(bus.d_valid), 64'd0);
        chk("access_a_ready", 64'(bus.a_ready), 64'd0);
        @(negedge clk);
        chk("latency_d_valid", 64'(bus.d_valid), 64'd1);
        if (bus.d_valid === 1'b1 && sb.size() > 0) begin
            e  = sb.pop_front();
            ew = {e.op, 3'd0, e.sz, e.src, e.data};
            chk("resp_channel", 64'(bus.d_channel), 64'(ew));
            chk("resp_error", 64'(bus.d_error), 64'(e.err));
            for (int k = 0; k < hold; k++) begin
                if (k % 2 == 0) begin
                    bus.a_valid   = 1'b1;
                    bus.a_channel = {3'd0, 3'd0, 3'd5, 2'd0, 10'd5, 32'h0};
                end else begin
                    bus.a_valid = 1'b0;
                end
                @(negedge clk);
                chk("hold_d_valid", 64'(bus.d_valid), 64'd1);
                chk("hold_channel", 64'(bus.d_channel), 64'(ew));
                chk("hold_error", 64'(bus.d_error), 64'(e.err));
                chk("hold_a_ready", 64'(bus.a_ready), 64'd0);
                chk("hold_bp", 64'(bus.backpressureslave), 64'd1);
            end
            bus.a_valid   = 1'b0;
            bus.a_channel = '0;
            bus.d_ready   = 1'b1;
            @(negedge clk);
            bus.d_ready = 1'b0;
            chk("done_d_valid", 64'(bus.d_valid), 64'd0);
            chk("done_d_error", 64'(bus.d_error), 64'd0);
            chk("done_a_ready", 64'(bus.a_ready), 64'd1);
            chk("done_bp", 64'(bus.backpressureslave), 64'd0);
        end
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = mk(3'd0, 3'd0, 3'd5, 2'd1, 10'd5,    32'hDEADBEEF, 3'd0, 1'b0, 32'h0);
        tbl[1]  = mk(3'd4, 3'd0, 3'd5, 2'd2, 10'd5,    32'h0,        3'd1, 1'b0, 32'hDEADBEEF);
        tbl[2]  = mk(3'd0, 3'd0, 3'd5, 2'd0, 10'd44,   32'h44444444, 3'd0, 1'b0, 32'h0);
        tbl[3]  = mk(3'd0, 3'd0, 3'd5, 2'd3, 10'd300,  32'h0BADBAD0, 3'd0, 1'b1, 32'h0);
        tbl[4]  = mk(3'd4, 3'd0, 3'd5, 2'd1, 10'd300,  32'h0,        3'd1, 1'b1, 32'h0);
        tbl[5]  = mk(3'd4, 3'd0, 3'd5, 2'd0, 10'd44,   32'h0,        3'd1, 1'b0, 32'h44444444);
        tbl[6]  = mk(3'd2, 3'd0, 3'd5, 2'd1, 10'd5,    32'h11111111, 3'd0, 1'b1, 32'h0);
        tbl[7]  = mk(3'd4, 3'd0, 3'd5, 2'd3, 10'd5,    32'h0,        3'd1, 1'b0, 32'hDEADBEEF);
        tbl[8]  = mk(3'd0, 3'd0, 3'd2, 2'd2, 10'd5,    32'h22222222, 3'd0, 1'b1, 32'h0);
        tbl[9]  = mk(3'd4, 3'd0, 3'd5, 2'd1, 10'd5,    32'h0,        3'd1, 1'b0, 32'hDEADBEEF);
        tbl[10] = mk(3'd0, 3'd0, 3'd5, 2'd0, 10'd7,    32'h12345678, 3'd0, 1'b0, 32'h0);
        tbl[11] = mk(3'd4, 3'd1, 3'd5, 2'd2, 10'd7,    32'h0,        3'd1, 1'b1, 32'h0);
        tbl[12] = mk(3'd4, 3'd0, 3'd2, 2'd3, 10'd7,    32'h0,        3'd1, 1'b1, 32'h0);
        tbl[13] = mk(3'd0, 3'd0, 3'd5, 2'd1, 10'd255,  32'hA5A5A5A5, 3'd0, 1'b0, 32'h0);
        tbl[14] = mk(3'd4, 3'd0, 3'd5, 2'd2, 10'd255,  32'h0,        3'd1, 1'b0, 32'hA5A5A5A5);
        tbl[15] = mk(3'd4, 3'd0, 3'd5, 2'd0, 10'd1023, 32'h0,        3'd1, 1'b1, 32'h0);
        tbl[16] = mk(3'd4, 3'd0, 3'd5, 2'd3, 10'd7,    32'h0,        3'd1, 1'b0, 32'h12345678);

        reset         = 1'b1;
        bus.a_valid   = 1'b0;
        bus.a_channel = '0;
        bus.d_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
        chk("rst_bp", 64'(bus.backpressureslave), 64'd1);
        chk("rst_d_valid", 64'(bus.d_valid), 64'd0);
        chk("rst_d_error", 64'(bus.d_error), 64'd0);
        chk("rst_d_channel", 64'(bus.d_channel), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_a_ready", 64'(bus.a_ready), 64'd1);
        chk("post_rst_bp", 64'(bus.backpressureslave), 64'd0);

        for (int i = 0; i < 17; i++) begin
            send(tbl[i], 0);
        end

        // Backpressure: response held for 5 cycles with stray request pulses, then re-read addr 5.
        send(mk(3'd4, 3'd0, 3'd5, 2'd2, 10'd5, 32'h0, 3'd1, 1'b0, 32'hDEADBEEF), 5);
        send(mk(3'd4, 3'd0, 3'd5, 2'd1, 10'd5, 32'h0, 3'd1, 1'b0, 32'hDEADBEEF), 0);

        // Reset lands on the ACCESS edge of a Put to addr 7.
        bus.a_channel = {3'd0, 3'd0, 3'd5, 2'd1, 10'd7, 32'hCAFEF00D};
        bus.a_valid   = 1'b1;
        @(negedge clk);
        bus.a_valid   = 1'b0;
        bus.a_channel = '0;
        reset         = 1'b1;
        @(negedge clk);
        chk("abort_d_valid", 64'(bus.d_valid), 64'd0);
        chk("abort_d_error", 64'(bus.d_error), 64'd0);
        chk("abort_d_channel", 64'(bus.d_channel), 64'd0);
        chk("abort_a_ready", 64'(bus.a_ready), 64'd0);
        chk("abort_bp", 64'(bus.backpressureslave), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rel_a_ready", 64'(bus.a_ready), 64'd1);
        send(mk(3'd4, 3'd0, 3'd5, 2'd0, 10'd7, 32'h0, 3'd1, 1'b0, 32'h12345678), 0);

        // Back-to-back with a_valid held high and d_ready always 1: three-cycle cadence.
        bus.d_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("b2b_a_ready", 64'(bus.a_ready), 64'(i % 3 == 0));
            chk("b2b_d_valid", 64'(bus.d_valid), 64'(i % 3 == 2));
            if (i % 3 == 2) begin
                chk("b2b_resp", 64'(bus.d_channel),
                    64'({3'd1, 3'd0, 3'd5, 2'(i / 3), 32'hDEADBEEF}));
            end
            if (i % 3 == 0 && i < 9) begin
                bus.a_valid   = 1'b1;
                bus.a_channel = {3'd4, 3'd0, 3'd5, 2'(i / 3), 10'd5, 32'h0};
            end else if (i == 9) begin
                bus.a_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.d_ready = 1'b0;
        chk("idle_after_b2b", 64'(bus.a_ready), 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
